dmem_mmio: RTL and testbench

- Data-memory slave sitting directly downstream of the pipelined core's Memory stage.
- Consumes the core's M-stage address, store data, write strobe and byte enables; returns load data to the core's data-read input.
- Contains a byte-lane-writable word RAM plus a small memory-mapped peripheral window: GPIO, a 64-bit free-running timer with compare interrupt, and a UART transmitter.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_uart_tx.sv | 75 +++++++
 rtl/dmem_mmio.sv | 103 ++++++++++
 tb/tb_dmem_mmio.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, timer compare reset value, UART state type and byte-lane merge helper
package dmem_pkg;

    localparam logic [2:0] OFF_GPIO_OUT  = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN   = 3'd1;
    localparam logic [2:0] OFF_TIME_LO   = 3'd2;
    localparam logic [2:0] OFF_TIME_HI   = 3'd3;
    localparam logic [2:0] OFF_CMP_LO    = 3'd4;
    localparam logic [2:0] OFF_CMP_HI    = 3'd5;
    localparam logic [2:0] OFF_UART_TX   = 3'd6;
    localparam logic [2:0] OFF_UART_STAT = 3'd7;

    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: 8N1 UART transmitter, LSB first, CLKS_PER_BIT clocks per bit
//   clk, clr (async active-low reset), start (accept data[7:0] when idle or finishing STOP),
//   busy (frame in progress), txd (serial line, idle high)
module dmem_uart_tx
    import dmem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_tick;

    assign w_tick = r_baud == LAST;
    assign busy   = r_state != IDLE;
    assign txd    = r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // The last STOP cycle may accept a new byte so back-to-back frames have no idle gap.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_tick ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (start) begin
                    w_state_nxt = START;
                    w_shift_nxt = data;
                end
            end
            START: if (w_tick) begin
                w_state_nxt = DATA;
                w_bit_nxt   = '0;
            end
            DATA: if (w_tick) begin
                w_shift_nxt = r_shift >> 1;
                w_bit_nxt   = r_bit + 3'd1;
                if (r_bit == 3'd7) w_state_nxt = STOP;
            end
            STOP: if (w_tick) begin
                w_state_nxt = start ? START : IDLE;
                if (start) w_shift_nxt = data;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data memory slave for the core M stage with RAM, GPIO, 64-bit timer and optional UART
//   Inputs : clk, clr (async active-low), ALUResultM (byte address), WriteDataM (lane-aligned),
//            MemWriteM (store strobe), byteEnable (lane enables), gpio_in (async)
//   Outputs: RD_data (combinational load data), gpio_out, timer_irq (registered), uart_txd
//   Macro  : DMEM_UART_EN compiles in the UART transmitter; otherwise uart_txd=1 and UART_STAT reads 0
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter int          GPIO_W       = 8,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] MMIO_BASE    = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic              MemWriteM,
    input  logic [3:0]        byteEnable,
    output logic [31:0]       RD_data,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              uart_txd
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]       r_mem [DEPTH];
    logic [GPIO_W-1:0] r_gpio_out, r_sync1, r_sync2;
    logic [63:0]       r_time, r_cmp;
    logic              r_irq;
    logic              w_ram_hit, w_mmio_hit, w_mmio_wr, w_uart_busy;
    logic [2:0]        w_off;
    logic [AW-1:0]     w_idx;
    logic [31:0]       w_gpio_wr;

    assign w_ram_hit  = ALUResultM < 32'(DEPTH * 4);
    assign w_mmio_hit = ALUResultM[31:5] == MMIO_BASE[31:5];
    assign w_mmio_wr  = MemWriteM && w_mmio_hit;
    assign w_off      = ALUResultM[4:2];
    assign w_idx      = ALUResultM[AW+1:2];
    assign w_gpio_wr  = lane_merge(32'(r_gpio_out), WriteDataM, byteEnable);
    assign gpio_out   = r_gpio_out;
    assign timer_irq  = r_irq;

    always_ff @(posedge clk) begin
        if (MemWriteM && w_ram_hit)
            for (int i = 0; i < 4; i++)
                if (byteEnable[i]) r_mem[w_idx][8*i +: 8] <= WriteDataM[8*i +: 8];
    end

    // irq compares the pre-edge time and cmp, so it trails the match by one cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_time     <= '0;
            r_cmp      <= CMP_RST;
            r_irq      <= 1'b0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_time  <= r_time + 64'd1;
            r_irq   <= r_time >= r_cmp;
            if (w_mmio_wr && w_off == OFF_GPIO_OUT) r_gpio_out <= w_gpio_wr[GPIO_W-1:0];
            if (w_mmio_wr && w_off == OFF_CMP_LO) r_cmp[31:0] <= lane_merge(r_cmp[31:0], WriteDataM, byteEnable);
            if (w_mmio_wr && w_off == OFF_CMP_HI) r_cmp[63:32] <= lane_merge(r_cmp[63:32], WriteDataM, byteEnable);
        end
    end

`ifdef DMEM_UART_EN
    dmem_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk  (clk),
        .clr  (clr),
        .start(w_mmio_wr && w_off == OFF_UART_TX && byteEnable[0]),
        .data (WriteDataM[7:0]),
        .busy (w_uart_busy),
        .txd  (uart_txd)
    );
`else
    assign w_uart_busy = 1'b0;
    assign uart_txd    = 1'b1;
`endif

    always_comb begin
        RD_data = '0;
        if (w_ram_hit) RD_data = r_mem[w_idx];
        else if (w_mmio_hit)
            case (w_off)
                OFF_GPIO_OUT:  RD_data = 32'(r_gpio_out);
                OFF_GPIO_IN:   RD_data = 32'(r_sync2);
                OFF_TIME_LO:   RD_data = r_time[31:0];
                OFF_TIME_HI:   RD_data = r_time[63:32];
                OFF_CMP_LO:    RD_data = r_cmp[31:0];
                OFF_CMP_HI:    RD_data = r_cmp[63:32];
                OFF_UART_STAT: RD_data = {31'b0, w_uart_busy};
                default:       RD_data = '0;
            endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: scoreboard bench for dmem_mmio against a cycle-level behavioural model
module tb_dmem_mmio;

    localparam int          DEPTH = 1024;
    localparam int          GW    = 8;
    localparam int          CPB   = 4;
    localparam logic [31:0] MB    = 32'h1000_0000;
`ifdef DMEM_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    logic          clk = 1'b0, clr = 1'b0, we = 1'b0;
    logic [31:0]   addr = '0, wdata = '0, rd;
    logic [3:0]    be = '0;
    logic [GW-1:0] gin = '0, gout;
    logic          irq, txd;

    always #5 clk = ~clk;

    dmem_mmio #(.DEPTH(DEPTH), .GPIO_W(GW), .CLKS_PER_BIT(CPB), .MMIO_BASE(MB)) dut (
        .clk(clk), .clr(clr), .ALUResultM(addr), .WriteDataM(wdata), .MemWriteM(we),
        .byteEnable(be), .RD_data(rd), .gpio_in(gin), .gpio_out(gout),
        .timer_irq(irq), .uart_txd(txd)
    );

    typedef struct {int kind; logic [31:0] exp; string name;} chk_t;
    chk_t sb[$];
    int   checks = 0, errors = 0;

    logic [31:0]   m_mem [32];
    logic [GW-1:0] m_gpio, m_s1, m_s2;
    logic [63:0]   m_time, m_cmp;
    logic          m_irq;
    bit            m_tx[$];

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (a < DEPTH * 4) return m_mem[a[6:2]];
        if (a[31:5] != MB[31:5]) return 0;
        case (a[4:2])
            0: return 32'(m_gpio);
            1: return 32'(m_s2);
            2: return m_time[31:0];
            3: return m_time[63:32];
            4: return m_cmp[31:0];
            5: return m_cmp[63:32];
            7: return {31'b0, m_tx.size() != 0};
            default: return 0;
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] e, input string n);
        chk_t c;
        c.kind = k; c.exp = e; c.name = n;
        sb.push_back(c);
    endtask

    task automatic upd();
        bit hit;
        hit   = addr[31:5] == MB[31:5];
        m_irq = m_time >= m_cmp;
        if (m_tx.size() != 0) void'(m_tx.pop_front());
        if (we) begin
            if (addr < 128) m_mem[addr[6:2]] = lanes(m_mem[addr[6:2]], wdata, be);
            if (hit && addr[4:2] == 0) m_gpio = GW'(lanes(32'(m_gpio), wdata, be));
            if (hit && addr[4:2] == 4) m_cmp[31:0] = lanes(m_cmp[31:0], wdata, be);
            if (hit && addr[4:2] == 5) m_cmp[63:32] = lanes(m_cmp[63:32], wdata, be);
            if (hit && addr[4:2] == 6 && be[0] && UART_EN && m_tx.size() == 0) begin
                repeat (CPB) m_tx.push_back(1'b0);
                for (int b = 0; b < 8; b++) repeat (CPB) m_tx.push_back(wdata[b]);
                repeat (CPB) m_tx.push_back(1'b1);
            end
        end
        m_time++;
        m_s2 = m_s1;
        m_s1 = gin;
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        we = w; addr = a; wdata = d; be = b;
        if (!(a < DEPTH * 4 && a >= 128)) push(0, mread(a), "rd_data");
        push(1, 32'(m_gpio), "gpio_out");
        push(2, {31'b0, m_irq}, "timer_irq");
        push(3, {31'b0, m_tx.size() != 0 ? m_tx[0] : 1'b1}, "uart_txd");
        @(posedge clk);
        if (clr) upd();
        #1;
    endtask

    task automatic areset();
        clr = 1'b0;
        m_gpio = '0; m_s1 = '0; m_s2 = '0;
        m_time = '0; m_cmp = '1; m_irq = 1'b0;
        m_tx.delete();
        step(0, MB + 28, 0, 0);
        step(0, MB + 8, 0, 0);
        clr = 1'b1;
    endtask

    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (sb.size() != 0) begin
            c   = sb.pop_front();
            act = c.kind == 0 ? rd : c.kind == 1 ? 32'(gout) : c.kind == 2 ? {31'b0, irq} : {31'b0, txd};
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s addr=%h got=%h want=%h t=%0t", c.name, addr, act, c.exp, $time);
            end
        end
    end

    initial begin
        #1;
        areset();
        step(1, MB + 20, 0, 4'hF);
        step(1, MB + 16, 20, 4'hF);
        repeat (25) step(0, MB + 8, 0, 0);
        step(1, MB + 16, '1, 4'hF);
        step(1, MB + 20, '1, 4'hF);
        repeat (3) step(0, MB + 8, 0, 0);
        for (int i = 0; i < 32; i++) step(1, 32'(i * 4), $urandom, 4'hF);
        step(1, 32'h40, 32'hDEADBEEF, 4'hF);
        step(1, 32'h40, 32'h000000AA, 4'h1);
        step(0, 32'h40, 0, 0);
        step(0, 32'h8000_0000, 0, 0);
        step(1, MB, 32'h5A, 4'hF);
        step(0, MB + 4, 0, 0);
        gin = 8'h3C;
        repeat (4) step(0, MB + 4, 0, 0);
        step(1, MB + 24, 32'hA5, 4'hF);
        repeat (10) step(0, MB + 28, 0, 0);
        step(1, MB + 24, 32'h33, 4'h1);
        for (int i = 0; i < 60 && m_tx.size() != 1; i++) step(0, MB + 28, 0, 0);
        if (UART_EN) begin
            checks++;
            if (m_tx.size() != 1) begin
                errors++;
                $display("FAIL uart_frame_end got=%0d want=1", m_tx.size());
            end
        end
        step(1, MB + 24, 32'h81, 4'h1);
        repeat (45) step(0, MB + 28, 0, 0);
        repeat (400) begin
            case ($urandom_range(0, 5))
                0: step(0, 32'($urandom_range(0, 31) * 4), 0, 0);
                1: step(1, 32'($urandom_range(0, 31) * 4), $urandom, 4'($urandom));
                2: step(0, MB + 32'($urandom_range(0, 7) * 4), 0, 0);
                3: step(1, MB + 32'($urandom_range(0, 7) * 4), $urandom, 4'($urandom));
                4: step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? MB + 32 : 32'(DEPTH * 4),
                        $urandom, 4'hF);
                default: begin
                    gin = GW'($urandom);
                    step(0, MB + 4, 0, 0);
                end
            endcase
        end
        step(1, MB, 32'hA5, 4'hF);
        step(1, MB + 20, 0, 4'hF);
        step(1, MB + 16, 0, 4'hF);
        repeat (CPB * 10 + 2) step(0, MB + 28, 0, 0);
        step(1, MB + 24, 32'h5C, 4'h1);
        repeat (12) step(0, MB + 28, 0, 0);
        areset();
        repeat (5) step(0, MB + 8, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
